// File: rtl/adc_switch_sequencer.sv
// Sequences the two-input ADC switch/summer through phases A (in0), B (in1), C (in0+in1).
// Latency: a CTRL write strobed in cycle t asserts k*_en/phase/busy in cycle t+2; all outputs registered.
// Backpressure: none; settings bus writes always accepted, sequencing free-runs until aborted or single-shot ends.
//
// Ports:
//   clock, reset                 - system clock, synchronous active-high reset
//   serial_addr/data/strobe      - settings bus (CTRL, DWELL, BLANK registers)
//   k0_en, k1_en                 - switch enables for in0 / in1 (1 = closed)
//   phase                        - 0 idle, 1 A, 2 B, 3 C
//   sample_valid                 - high on acquire cycles
//   frame_done                   - pulse on last acquire cycle of the highest enabled phase
//   busy                         - high whenever not idle
module adc_switch_sequencer #(
  parameter logic [6:0] ADDR_CTRL  = 7'd80,
  parameter logic [6:0] ADDR_DWELL = 7'd81,
  parameter logic [6:0] ADDR_BLANK = 7'd82
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  serial_addr,
  input  logic [31:0] serial_data,
  input  logic        serial_strobe,
  output logic        k0_en,
  output logic        k1_en,
  output logic [1:0]  phase,
  output logic        sample_valid,
  output logic        frame_done,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_ACQ   = 2'd2
  } state_t;

  state_t      state;
  state_t      nxt_state;
  logic [4:0]  ctrl;
  logic [15:0] dwell;
  logic [15:0] blank;
  logic [15:0] shadow_dwell;
  logic [15:0] cnt;
  logic [1:0]  cur_ph;

  logic [1:0]  nxt_ph;
  logic [15:0] nxt_cnt;
  logic [15:0] nxt_shadow;
  logic        nxt_fd;
  logic        enter;
  logic [1:0]  enter_ph;
  logic        abort;

  logic        enable;
  logic [2:0]  mask;
  logic        single_shot;
  logic        unused_data;

  assign enable      = ctrl[0];
  assign mask        = ctrl[3:1];
  assign single_shot = ctrl[4];
  // Upper settings-bus bits carry nothing for this block.
  assign unused_data = ^serial_data[31:16];

  function automatic logic ph_enabled(input logic [1:0] ph, input logic [2:0] m);
    case (ph)
      2'd1:    ph_enabled = m[0];
      2'd2:    ph_enabled = m[1];
      2'd3:    ph_enabled = m[2];
      default: ph_enabled = 1'b0;
    endcase
  endfunction

  // Next enabled phase after cur in A->B->C->A order; cur=0 yields the first
  // enabled phase, and a lone enabled phase returns itself.
  function automatic logic [1:0] first_after(input logic [1:0] cur, input logic [2:0] m);
    logic [1:0] p;
    first_after = 2'd0;
    p = cur;
    for (int i = 0; i < 3; i++) begin
      p = (p == 2'd3) ? 2'd1 : p + 2'd1;
      if (ph_enabled(p, m) && (first_after == 2'd0)) first_after = p;
    end
  endfunction

  function automatic logic [1:0] highest(input logic [2:0] m);
    if (m[2])      highest = 2'd3;
    else if (m[1]) highest = 2'd2;
    else if (m[0]) highest = 2'd1;
    else           highest = 2'd0;
  endfunction

  always_comb begin
    nxt_state  = state;
    nxt_ph     = cur_ph;
    nxt_cnt    = cnt;
    nxt_shadow = shadow_dwell;
    enter      = 1'b0;
    enter_ph   = 2'd0;
    abort      = (state != S_IDLE) && (!enable || !ph_enabled(cur_ph, mask));

    case (state)
      S_IDLE: begin
        if (enable && (mask != 3'd0)) begin
          enter    = 1'b1;
          enter_ph = first_after(2'd0, mask);
        end
      end
      S_BLANK: begin
        if (abort) begin
          nxt_state = S_IDLE;
        end else if (cnt == 16'd1) begin
          nxt_state = S_ACQ;
          nxt_cnt   = (shadow_dwell == 16'd0) ? 16'd1 : shadow_dwell;
        end else begin
          nxt_cnt = cnt - 16'd1;
        end
      end
      S_ACQ: begin
        if (abort) begin
          nxt_state = S_IDLE;
        end else if (cnt == 16'd1) begin
          // The registered frame_done marks this as the frame's final cycle.
          if (frame_done && single_shot) begin
            nxt_state = S_IDLE;
          end else begin
            enter    = 1'b1;
            enter_ph = first_after(cur_ph, mask);
          end
        end else begin
          nxt_cnt = cnt - 16'd1;
        end
      end
      default: nxt_state = S_IDLE;
    endcase

    // Phase entry: snapshot DWELL for this phase; BLANK loads the counter
    // directly, and a zero BLANK drops straight into acquire.
    if (enter) begin
      nxt_ph     = enter_ph;
      nxt_shadow = dwell;
      if (blank != 16'd0) begin
        nxt_state = S_BLANK;
        nxt_cnt   = blank;
      end else begin
        nxt_state = S_ACQ;
        nxt_cnt   = (dwell == 16'd0) ? 16'd1 : dwell;
      end
    end

    if (nxt_state == S_IDLE) begin
      nxt_ph  = 2'd0;
      nxt_cnt = 16'd0;
    end

    nxt_fd = (nxt_state == S_ACQ) && (nxt_cnt == 16'd1) && (nxt_ph == highest(mask));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      ctrl         <= 5'd0;
      dwell        <= 16'd0;
      blank        <= 16'd0;
      shadow_dwell <= 16'd0;
      cnt          <= 16'd0;
      cur_ph       <= 2'd0;
      k0_en        <= 1'b0;
      k1_en        <= 1'b0;
      phase        <= 2'd0;
      sample_valid <= 1'b0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= nxt_state;
      cnt          <= nxt_cnt;
      cur_ph       <= nxt_ph;
      shadow_dwell <= nxt_shadow;

      k0_en        <= (nxt_ph == 2'd1) || (nxt_ph == 2'd3);
      k1_en        <= (nxt_ph == 2'd2) || (nxt_ph == 2'd3);
      phase        <= nxt_ph;
      sample_valid <= (nxt_state == S_ACQ);
      frame_done   <= nxt_fd;
      busy         <= (nxt_state != S_IDLE);

      // A bus write to CTRL takes priority over the single-shot self-clear.
      if (serial_strobe && (serial_addr == ADDR_CTRL)) begin
        ctrl <= serial_data[4:0];
      end else if (frame_done && single_shot) begin
        ctrl[0] <= 1'b0;
      end
      if (serial_strobe && (serial_addr == ADDR_DWELL)) dwell <= serial_data[15:0];
      if (serial_strobe && (serial_addr == ADDR_BLANK)) blank <= serial_data[15:0];
    end
  end

endmodule

// File: tb/tb_adc_switch_sequencer.sv
// Scoreboarded bench for adc_switch_sequencer: a phase-plan reference model
// predicts every cycle's outputs; a separate monitor compares at negedge.
module tb_adc_switch_sequencer;

  localparam logic [6:0] A_CTRL  = 7'd80;
  localparam logic [6:0] A_DWELL = 7'd81;
  localparam logic [6:0] A_BLANK = 7'd82;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  serial_addr = 7'd0;
  logic [31:0] serial_data = 32'd0;
  logic        serial_strobe = 1'b0;
  logic        k0_en, k1_en, sample_valid, frame_done, busy;
  logic [1:0]  phase;

  always #5 clock = ~clock;

  adc_switch_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .serial_addr  (serial_addr),
    .serial_data  (serial_data),
    .serial_strobe(serial_strobe),
    .k0_en        (k0_en),
    .k1_en        (k1_en),
    .phase        (phase),
    .sample_valid (sample_valid),
    .frame_done   (frame_done),
    .busy         (busy)
  );

  typedef struct packed {
    logic       k0;
    logic       k1;
    logic [1:0] ph;
    logic       sv;
    logic       fd;
    logic       busy;
  } out_t;

  typedef struct packed {
    logic [1:0] ph;
    logic       acq;
    logic       last;
  } step_t;

  int n_tests = 0;
  int n_fail  = 0;

  out_t  exp_q[$];
  step_t plan[$];
  logic [4:0]  m_ctrl  = 5'd0;
  logic [15:0] m_dwell = 16'd0;
  logic [15:0] m_blank = 16'd0;
  out_t        m_out   = '0;
  bit          model_on = 1'b0;
  int          cyc = 0;

  // ---------------- reference model ----------------
  function automatic logic [1:0] top_phase(input logic [2:0] m);
    for (int k = 3; k >= 1; k--) if (m[k-1]) return 2'(k);
    return 2'd0;
  endfunction

  function automatic logic [1:0] next_phase(input logic [1:0] cur, input logic [2:0] m);
    int p;
    for (int k = 1; k <= 3; k++) begin
      p = ((int'(cur) + k - 1) % 3) + 1;
      if (m[p-1]) return 2'(p);
    end
    return 2'd0;
  endfunction

  // A whole phase laid out up front: BLANK settle entries then acquire entries.
  function automatic void make_plan(input logic [1:0] p);
    int nb;
    int na;
    nb = int'(m_blank);
    na = (m_dwell == 16'd0) ? 1 : int'(m_dwell);
    for (int i = 0; i < nb; i++) plan.push_back('{ph: p, acq: 1'b0, last: 1'b0});
    for (int i = 0; i < na; i++) plan.push_back('{ph: p, acq: 1'b1, last: (i == na - 1)});
  endfunction

  function automatic out_t to_out(input step_t s, input logic fd);
    out_t o;
    o.k0   = (s.ph == 2'd1) || (s.ph == 2'd3);
    o.k1   = (s.ph == 2'd2) || (s.ph == 2'd3);
    o.ph   = s.ph;
    o.sv   = s.acq;
    o.fd   = fd;
    o.busy = 1'b1;
    return o;
  endfunction

  always @(posedge clock) begin
    out_t       nxt;
    step_t      s;
    logic       en;
    logic [2:0] mask;
    logic       ctrl_wr;
    cyc++;
    nxt = '0;
    if (reset) begin
      m_ctrl  = 5'd0;
      m_dwell = 16'd0;
      m_blank = 16'd0;
      plan.delete();
      model_on = 1'b1;
    end else if (model_on) begin
      en   = m_ctrl[0];
      mask = m_ctrl[3:1];
      if (m_out.busy && (!en || !mask[int'(m_out.ph) - 1])) begin
        plan.delete();
      end else begin
        if (plan.size() == 0) begin
          if (m_out.busy) begin
            if (!(m_out.fd && m_ctrl[4])) make_plan(next_phase(m_out.ph, mask));
          end else if (en && (mask != 3'd0)) begin
            make_plan(next_phase(2'd0, mask));
          end
        end
        if (plan.size() > 0) begin
          s   = plan.pop_front();
          nxt = to_out(s, s.acq && s.last && (s.ph == top_phase(mask)));
        end
      end
      ctrl_wr = serial_strobe && (serial_addr == A_CTRL);
      if (ctrl_wr) m_ctrl = serial_data[4:0];
      else if (m_out.fd && m_ctrl[4]) m_ctrl[0] = 1'b0;
      if (serial_strobe && (serial_addr == A_DWELL)) m_dwell = serial_data[15:0];
      if (serial_strobe && (serial_addr == A_BLANK)) m_blank = serial_data[15:0];
    end
    if (model_on) begin
      m_out = nxt;
      exp_q.push_back(nxt);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    out_t e;
    out_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{k0: k0_en, k1: k1_en, ph: phase, sv: sample_valid, fd: frame_done, busy: busy};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs @cycle %0d: got k0=%b k1=%b ph=%0d sv=%b fd=%b busy=%b, expected k0=%b k1=%b ph=%0d sv=%b fd=%b busy=%b",
                 cyc, a.k0, a.k1, a.ph, a.sv, a.fd, a.busy, e.k0, e.k1, e.ph, e.sv, e.fd, e.busy);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      serial_addr = 7'($urandom);
      serial_data = $urandom;
      tick();
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    serial_addr   = a;
    serial_data   = d;
    serial_strobe = 1'b1;
    tick();
    serial_strobe = 1'b0;
    serial_addr   = 7'($urandom);
    serial_data   = $urandom;
  endtask

  // Directed timeline after CTRL=0x07 strobed in cycle 0 (BLANK=2, DWELL=3):
  // {phase, k0, k1, sample_valid, frame_done}
  function automatic logic [5:0] scen2_exp(input int c);
    if (c <= 1)  return 6'b00_0000;
    if (c <= 3)  return 6'b01_1000;
    if (c <= 6)  return 6'b01_1010;
    if (c <= 8)  return 6'b10_0100;
    if (c <= 10) return 6'b10_0110;
    if (c == 11) return 6'b10_0111;
    return 6'b01_1000;
  endfunction

  initial begin
    logic [31:0] d;
    logic [5:0]  got;
    logic [5:0]  want;
    int          r;
    bit          found;

    // Scenario 1: reset then 20 quiet cycles.
    tick(); tick();
    reset = 1'b0;
    idle_cycles(20);

    // Scenario 2: A,B with BLANK=2, DWELL=3; explicit timeline check.
    wr(A_BLANK, 32'd2);
    wr(A_DWELL, 32'd3);
    wr(A_CTRL, 32'h07);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      got  = {phase, k0_en, k1_en, sample_valid, frame_done};
      want = scen2_exp(c);
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL scen2_cycle%0d: got {ph,k0,k1,sv,fd}=%b, expected %b", c, got, want);
      end
      @(posedge clock);
      #1;
    end

    // Scenario 4: now in A blank (cycle 13); A acquire starts next cycle.
    tick();
    wr(A_DWELL, 32'd5);
    idle_cycles(25);

    // Scenario 5: abort via enable, then restart.
    wr(A_CTRL, 32'h06);
    idle_cycles(5);
    wr(A_CTRL, 32'h07);
    idle_cycles(20);

    // Scenario 6: reset during phase B acquire (bounded search).
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (phase == 2'd2 && sample_valid) found = 1'b1;
      else tick();
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL scen6_find_B_acq: got no B acquire in 60 cycles, expected one");
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_cycles(20);

    // Scenario 3: C only, single-shot, zero BLANK/DWELL.
    wr(A_BLANK, 32'd0);
    wr(A_DWELL, 32'd0);
    wr(A_CTRL, 32'h19);
    idle_cycles(10);

    // Single-shot clear colliding with a CTRL rewrite: bus write must win.
    wr(A_DWELL, 32'd2);
    wr(A_CTRL, 32'h13);
    tick(); tick();
    wr(A_CTRL, 32'h13);
    idle_cycles(12);
    wr(A_CTRL, 32'h00);
    idle_cycles(4);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 1) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end else if (r < 6) begin
        d = $urandom;
        d[4:0] = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
        wr(A_CTRL, d);
      end else if (r < 9) begin
        d = $urandom;
        d[15:0] = 16'($urandom_range(0, 4));
        wr(A_DWELL, d);
      end else if (r < 12) begin
        d = $urandom;
        d[15:0] = 16'($urandom_range(0, 3));
        wr(A_BLANK, d);
      end else if (r < 14) begin
        wr(7'($urandom_range(83, 127)), $urandom);
      end else begin
        idle_cycles(1);
      end
    end

    idle_cycles(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_switch_sequencer.md
Name: adc_switch_sequencer

Overview:
Controller that time-multiplexes the two-input ADC switch/summer. It drives the per-input switch enables through a programmable cycle of phases: A = in0 only, B = in1 only, C = in0+in1. Each phase is a settling (blank) interval followed by an acquire interval, and sample_valid marks usable summed samples for downstream filters. Configuration arrives over the standard serial settings bus (addr/data/strobe), with reset value 0 for every register.

Parameters:
ADDR_CTRL, 7'd80, settings address of control register
ADDR_DWELL, 7'd81, settings address of acquire length (bits [15:0])
ADDR_BLANK, 7'd82, settings address of blank length (bits [15:0])

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
serial_addr  input  7  settings bus address
serial_data  input  32  settings bus data
serial_strobe  input  1  settings bus write strobe
k0_en  output  1  switch enable for in0 (1 = closed)
k1_en  output  1  switch enable for in1
phase  output  2  0 = idle, 1 = A, 2 = B, 3 = C
sample_valid  output  1  high during acquire cycles
frame_done  output  1  1-cycle pulse on last acquire cycle of last enabled phase
busy  output  1  high whenever not IDLE

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset state: all registers 0, FSM IDLE, every output 0.
- Register writes: a register is written on the edge when serial_strobe=1 and serial_addr matches its address.
- CTRL bits:
  - [0] enable.
  - [1] phase A enable.
  - [2] phase B enable.
  - [3] phase C enable.
  - [4] single-shot.
  - Other bits are ignored and read as 0.
- Shadow copies: DWELL and BLANK are copied into shadow registers on entry to each phase's BLANK state. Writes mid-phase take effect from the next phase.
- Phase order: A→B→C→A, skipping phases whose mask bit is 0.
- Outputs per phase:
  - A: k0_en=1, k1_en=0.
  - B: k0_en=0, k1_en=1.
  - C: k0_en=1, k1_en=1.
  - IDLE: k0_en=0, k1_en=0, phase=0.
- FSM states: IDLE, BLANK, ACQ. All outputs are registered.
  - IDLE→BLANK(first enabled phase) when enable=1 and mask≠0. If mask=0, remain IDLE.
  - BLANK lasts shadow_blank cycles. If shadow_blank=0, BLANK is skipped and the phase enters ACQ directly. sample_valid=0 during BLANK.
  - ACQ lasts max(shadow_dwell,1) cycles with sample_valid=1. On its last cycle, the FSM moves to the next enabled phase's BLANK or ACQ state.
  - If only one phase is enabled, the FSM re-enters the same phase, including its blank interval.
- frame_done: asserted on the last ACQ cycle of the highest-ordered enabled phase (C > B > A).
- Single-shot: when single-shot=1, frame_done also clears CTRL[0] and the FSM returns to IDLE on the next cycle.
  - If a CTRL write occurs in the same cycle as the single-shot clear, the bus write wins.
- Latency: for a CTRL write strobed in cycle t, k*_en/phase/busy first assert in cycle t+2.
- Abort: CTRL[0] cleared, or the current phase's mask bit cleared, while running → the FSM enters IDLE on the next edge and all outputs go to 0.
  - Re-enable always restarts at the first enabled phase, never mid-frame.
- Mask changes: changes to other phases' mask bits while running are applied at the next phase boundary.
- Reset mid-operation: immediate return to the reset state on the next edge, including all registers.
- Counters: 16-bit counters, counting down, with no wrap. DWELL=16'hFFFF gives 65535 acquire cycles.

Test Plan:
1. After reset, hold serial_strobe=0 for 20 cycles → all outputs remain 0 and busy=0.
2. BLANK=2, DWELL=3, CTRL=0x07 (A,B, enable) with the CTRL strobe in cycle 0 → cycle-by-cycle response:
   - cycles 2–3: phase=1, k0_en=1, sample_valid=0.
   - cycles 4–6: phase=1, sample_valid=1.
   - cycles 7–8: phase=2, k1_en=1, sample_valid=0.
   - cycles 9–11: phase=2, sample_valid=1.
   - cycle 11: frame_done=1.
   - cycle 12: phase=1 again.
3. BLANK=0, DWELL=0, CTRL=0x19 (C, single-shot) → phase=3 for exactly 1 cycle with k0_en=k1_en=sample_valid=frame_done=1, then IDLE; CTRL[0] then reads back as 0 via the FSM staying idle.
4. Running as in scenario 2, write DWELL=5 during phase A acquire → A keeps 3 acquire cycles and B gets 5.
5. Running, write CTRL=0x06 (enable cleared) → next cycle all outputs 0. Rewrite 0x07 → restarts at phase A after the 2-cycle latency.
6. Assert reset for 1 cycle mid-ACQ of phase B → outputs 0 next cycle. CTRL, DWELL and BLANK are cleared, so the FSM stays IDLE with no further writes.
